alu_issue: RTL and testbench
============================

# alu_issue

Multi-cycle issue/capture controller on the initiating side of the 64-bit ALU datapath interface. It accepts one decoded LEGv8 instruction per handshake, decodes the 11-bit opcode into the 4-bit ALU control code, and drives registered A/B operands plus control to the ALU. It then captures the ALU result and zero flag and presents them downstream with valid/ready flow control. It sits in the execute stage between register read and memory/writeback.

## Interface
- No parameters; data width fixed at 64, control width fixed at 4.
- CLK  in  1  rising-edge clock
- RESET  in  1  synchronous, active-high reset
- IN_VALID  in  1  upstream instruction valid
- IN_READY  out  1  controller can accept an instruction
- OPCODE  in  11  LEGv8 opcode field, instruction bits [31:21]
- RD1  in  64  register read data 1
- RD2  in  64  register read data 2
- IMM  in  64  sign-extended immediate
- ALU_A  out  64  operand A to ALU
- ALU_B  out  64  operand B to ALU
- ALU_CONTROL  out  4  ALU op: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 PASS B, 1100 NOR
- ALU_RESULT  in  64  combinational ALU result
- ALU_ZERO  in  1  combinational ALU zero flag
- OUT_VALID  out  1  captured result valid
- OUT_READY  in  1  downstream accepts result
- RESULT  out  64  captured ALU result
- ZERO  out  1  captured zero flag
- BRANCH_TAKEN  out  1  CBZ/CBNZ resolution
- ILLEGAL  out  1  opcode not decoded

## Operation
- Decode, with x = don't care:
  - ADD 10001011000 → A=RD1, B=RD2, 0010.
  - SUB 11001011000 → 0110.
  - AND 10001010000 → 0000.
  - ORR 10101010000 → 0001.
  - ADDI 1001000100x → A=RD1, B=IMM, 0010.
  - SUBI 1101000100x → A=RD1, B=IMM, 0110.
  - LDUR 11111000010 and STUR 11111000000 → A=RD1, B=IMM, 0010.
  - CBZ 10110100xxx and CBNZ 10110101xxx → A=RD1, B=RD2, 0111 (PASS B).
- Anything else is illegal: ALU_CONTROL=0000, A=B=0, RESULT forced 0, ZERO=1, ILLEGAL=1, BRANCH_TAKEN=0.
- BRANCH_TAKEN is set only for CBZ/CBNZ: CBZ → ALU_ZERO, CBNZ → !ALU_ZERO.
- FSM states:
  - IDLE: IN_READY=1. On IN_VALID, latch the decode and operands and go to EXEC.
  - EXEC: ALU inputs are driven from registers. Capture ALU_RESULT, ALU_ZERO and the branch decision at the clock edge, then go to HOLD.
  - HOLD: OUT_VALID=1. On OUT_READY go to IDLE.
- Only one instruction is outstanding; there is no bypass from HOLD to EXEC.
- RESULT, ZERO, BRANCH_TAKEN and ILLEGAL are stable while OUT_VALID=1 and !OUT_READY.
- ALU_A, ALU_B and ALU_CONTROL hold their last registered values outside EXEC. They are only meaningful in EXEC.

## Timing
- Reset values: state IDLE, IN_READY=1 (combinational from IDLE), OUT_VALID=0, ALU_A=0, ALU_B=0, ALU_CONTROL=0000, RESULT=0, ZERO=0, BRANCH_TAKEN=0, ILLEGAL=0.
- Accept handshake: IN_VALID&&IN_READY at edge N.
- EXEC occupies cycle N+1, with the ALU driven for the full cycle.
- OUT_VALID rises in cycle N+2. Minimum latency is 2 cycles; throughput is one instruction per 3 cycles with OUT_READY held high.
- IN_READY is 0 in EXEC and HOLD. IN_VALID in those states is ignored and not latched.
- Output handshake completes at the edge where OUT_VALID&&OUT_READY. The next accept is possible at the following edge.
- RESET asserted in any state returns the block to IDLE at the next edge. It drops any in-flight instruction, and no OUT_VALID is produced for it.
- Arithmetic wraps modulo 2^64 inside the ALU; the controller performs no width extension.

## Structure
- Shared package `legv8_pkg` holds:
  - The ALU control localparams (AND/OR/ADD/SUB/PASS/NOR).
  - The opcode match constants and masks.
  - The FSM state enum.
- One natural sub-module, `alu_op_decode`: pure combinational OPCODE → {control, b_sel_imm, is_cbz, is_cbnz, illegal}.
- The FSM and registers live in `alu_issue`.

## Test plan
- ADD: RD1=5, RD2=7, accept at N → ALU_CONTROL=0010 in N+1, OUT_VALID in N+2 with RESULT=12, ZERO=0, ILLEGAL=0.
- SUBI: RD1=3, IMM=3 → ALU_CONTROL=0110, RESULT=0, ZERO=1. SUB: RD1=0, RD2=1 → RESULT=0xFFFF_FFFF_FFFF_FFFF.
- CBZ with RD2=0 → BRANCH_TAKEN=1. CBNZ with RD2=0 → BRANCH_TAKEN=0. CBNZ with RD2=9 → BRANCH_TAKEN=1, RESULT=9.
- Backpressure: hold OUT_READY=0 for 5 cycles with IN_VALID=1 and a new opcode → IN_READY=0 throughout, outputs stable, second instruction accepted only the cycle after the output handshake.
- Opcode 00000000000 → ILLEGAL=1, RESULT=0, ZERO=1, BRANCH_TAKEN=0.
- RESET asserted during EXEC → next cycle IDLE, IN_READY=1, OUT_VALID stays 0, all registered outputs zero.

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared LEGv8 execute-stage definitions: ALU control codes, opcode match
// constants/masks, issue FSM states and the decoded-op bundle.
package legv8_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_PASS = 4'b0111;
    localparam logic [3:0] ALU_NOR  = 4'b1100;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADDI = 11'b10010001000;
    localparam logic [10:0] OP_SUBI = 11'b11010001000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100000;
    localparam logic [10:0] OP_CBNZ = 11'b10110101000;

    localparam logic [10:0] OPM_EXACT = 11'b11111111111;
    localparam logic [10:0] OPM_IMM   = 11'b11111111110;
    localparam logic [10:0] OPM_CB    = 11'b11111111000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_HOLD
    } state_e;

    typedef struct packed {
        logic [3:0] ctrl;
        logic       b_sel_imm;
        logic       is_cbz;
        logic       is_cbnz;
        logic       illegal;
    } dec_t;

    function automatic logic op_match(input logic [10:0] op,
                                      input logic [10:0] match,
                                      input logic [10:0] mask);
        return (op & mask) == match;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Pure combinational LEGv8 opcode to ALU control decode.
module alu_op_decode
    import legv8_pkg::*;
(
    input  logic [10:0] opcode_i,
    output dec_t        dec_o
);

    always_comb begin
        dec_o.ctrl      = ALU_AND;
        dec_o.b_sel_imm = 1'b0;
        dec_o.is_cbz    = 1'b0;
        dec_o.is_cbnz   = 1'b0;
        dec_o.illegal   = 1'b0;
        if (op_match(opcode_i, OP_ADD, OPM_EXACT)) begin
            dec_o.ctrl = ALU_ADD;
        end else if (op_match(opcode_i, OP_SUB, OPM_EXACT)) begin
            dec_o.ctrl = ALU_SUB;
        end else if (op_match(opcode_i, OP_AND, OPM_EXACT)) begin
            dec_o.ctrl = ALU_AND;
        end else if (op_match(opcode_i, OP_ORR, OPM_EXACT)) begin
            dec_o.ctrl = ALU_OR;
        end else if (op_match(opcode_i, OP_ADDI, OPM_IMM)) begin
            dec_o.ctrl      = ALU_ADD;
            dec_o.b_sel_imm = 1'b1;
        end else if (op_match(opcode_i, OP_SUBI, OPM_IMM)) begin
            dec_o.ctrl      = ALU_SUB;
            dec_o.b_sel_imm = 1'b1;
        end else if (op_match(opcode_i, OP_LDUR, OPM_EXACT) ||
                     op_match(opcode_i, OP_STUR, OPM_EXACT)) begin
            dec_o.ctrl      = ALU_ADD;
            dec_o.b_sel_imm = 1'b1;
        end else if (op_match(opcode_i, OP_CBZ, OPM_CB)) begin
            dec_o.ctrl   = ALU_PASS;
            dec_o.is_cbz = 1'b1;
        end else if (op_match(opcode_i, OP_CBNZ, OPM_CB)) begin
            dec_o.ctrl    = ALU_PASS;
            dec_o.is_cbnz = 1'b1;
        end else begin
            dec_o.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/alu_issue.sv
// Execute-stage issue/capture controller: one instruction in flight through
// IDLE (accept) -> EXEC (drive ALU) -> HOLD (present result).
module alu_issue
    import legv8_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [10:0] OPCODE,
    input  logic [63:0] RD1,
    input  logic [63:0] RD2,
    input  logic [63:0] IMM,
    output logic [63:0] ALU_A,
    output logic [63:0] ALU_B,
    output logic [3:0]  ALU_CONTROL,
    input  logic [63:0] ALU_RESULT,
    input  logic        ALU_ZERO,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [63:0] RESULT,
    output logic        ZERO,
    output logic        BRANCH_TAKEN,
    output logic        ILLEGAL
);

    dec_t   dec;
    state_e state_q, state_d;

    logic [63:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic        cbz_q, cbz_d, cbnz_q, cbnz_d, ill_q, ill_d;
    logic        zero_q, zero_d, br_q, br_d, illegal_q, illegal_d;

    alu_op_decode u_dec (
        .opcode_i (OPCODE),
        .dec_o    (dec)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        ctrl_d    = ctrl_q;
        cbz_d     = cbz_q;
        cbnz_d    = cbnz_q;
        ill_d     = ill_q;
        result_d  = result_q;
        zero_d    = zero_q;
        br_d      = br_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_IDLE: begin
                if (IN_VALID) begin
                    state_d = ST_EXEC;
                    cbz_d   = dec.is_cbz;
                    cbnz_d  = dec.is_cbnz;
                    ill_d   = dec.illegal;
                    if (dec.illegal) begin
                        a_d    = '0;
                        b_d    = '0;
                        ctrl_d = ALU_AND;
                    end else begin
                        a_d    = RD1;
                        b_d    = dec.b_sel_imm ? IMM : RD2;
                        ctrl_d = dec.ctrl;
                    end
                end
            end
            ST_EXEC: begin
                // Illegal ops override whatever the ALU returns for A=B=0.
                state_d   = ST_HOLD;
                result_d  = ill_q ? '0 : ALU_RESULT;
                zero_d    = ill_q ? 1'b1 : ALU_ZERO;
                br_d      = (cbz_q & ALU_ZERO) | (cbnz_q & ~ALU_ZERO);
                illegal_d = ill_q;
            end
            ST_HOLD: begin
                if (OUT_READY) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            ctrl_q    <= ALU_AND;
            cbz_q     <= 1'b0;
            cbnz_q    <= 1'b0;
            ill_q     <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            br_q      <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            ctrl_q    <= ctrl_d;
            cbz_q     <= cbz_d;
            cbnz_q    <= cbnz_d;
            ill_q     <= ill_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            br_q      <= br_d;
            illegal_q <= illegal_d;
        end
    end

    assign IN_READY     = (state_q == ST_IDLE);
    assign OUT_VALID    = (state_q == ST_HOLD);
    assign ALU_A        = a_q;
    assign ALU_B        = b_q;
    assign ALU_CONTROL  = ctrl_q;
    assign RESULT       = result_q;
    assign ZERO         = zero_q;
    assign BRANCH_TAKEN = br_q;
    assign ILLEGAL      = illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed-vector bench for alu_issue with a behavioural 64-bit ALU attached.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] opcode;
    logic [63:0] rd1, rd2, imm;
    logic [63:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_control;
    logic        alu_zero;
    logic        out_valid, out_ready;
    logic [63:0] result;
    logic        zero, branch_taken, illegal;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_issue dut (
        .CLK          (clk),
        .RESET        (reset),
        .IN_VALID     (in_valid),
        .IN_READY     (in_ready),
        .OPCODE       (opcode),
        .RD1          (rd1),
        .RD2          (rd2),
        .IMM          (imm),
        .ALU_A        (alu_a),
        .ALU_B        (alu_b),
        .ALU_CONTROL  (alu_control),
        .ALU_RESULT   (alu_result),
        .ALU_ZERO     (alu_zero),
        .OUT_VALID    (out_valid),
        .OUT_READY    (out_ready),
        .RESULT       (result),
        .ZERO         (zero),
        .BRANCH_TAKEN (branch_taken),
        .ILLEGAL      (illegal)
    );

    always_comb begin
        alu_result = '0;
        case (alu_control)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0010: alu_result = alu_a + alu_b;
            4'b0110: alu_result = alu_a - alu_b;
            4'b0111: alu_result = alu_b;
            4'b1100: alu_result = ~(alu_a | alu_b);
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == 64'd0);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Present one instruction in IDLE, check EXEC drive and HOLD capture, then drain.
    task automatic run_op(input string tag, input logic [10:0] op,
                          input logic [63:0] r1, input logic [63:0] r2, input logic [63:0] im,
                          input logic [3:0] e_ctrl, input logic [63:0] e_a, input logic [63:0] e_b,
                          input logic [63:0] e_res, input logic e_zero, input logic e_br,
                          input logic e_ill);
        check({tag, ".in_ready"}, {63'd0, in_ready}, 64'd1);
        in_valid  = 1'b1;
        opcode    = op;
        rd1       = r1;
        rd2       = r2;
        imm       = im;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, ".exec_ctrl"}, {60'd0, alu_control}, {60'd0, e_ctrl});
        check({tag, ".exec_a"}, alu_a, e_a);
        check({tag, ".exec_b"}, alu_b, e_b);
        check({tag, ".exec_ready"}, {62'd0, in_ready, out_valid}, 64'd0);
        @(posedge clk); #1;
        check({tag, ".hold_valid"}, {63'd0, out_valid}, 64'd1);
        check({tag, ".result"}, result, e_res);
        check({tag, ".flags"}, {61'd0, zero, branch_taken, illegal}, {61'd0, e_zero, e_br, e_ill});
        @(posedge clk); #1;
        check({tag, ".drained"}, {62'd0, in_ready, out_valid}, 64'd2);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        opcode    = '0;
        rd1       = '0;
        rd2       = '0;
        imm       = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset.handshake", {62'd0, in_ready, out_valid}, 64'd2);
        check("reset.alu", {alu_a[29:0], alu_b[29:0], alu_control}, 64'd0);
        check("reset.out", {result[60:0], zero, branch_taken, illegal}, 64'd0);

        //     tag     opcode          RD1             RD2             IMM             ctrl     A               B               RESULT          Z     BR    ILL
        run_op("add",  11'b10001011000, 64'd5,         64'd7,          64'd0,          4'b0010, 64'd5,          64'd7,          64'd12,         1'b0, 1'b0, 1'b0);
        run_op("subi", 11'b11010001000, 64'd3,         64'd99,         64'd3,          4'b0110, 64'd3,          64'd3,          64'd0,          1'b1, 1'b0, 1'b0);
        run_op("sub",  11'b11001011000, 64'd0,         64'd1,          64'd0,          4'b0110, 64'd0,          64'd1,          64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
        run_op("and",  11'b10001010000, 64'hF0F0,      64'hFF00,       64'd0,          4'b0000, 64'hF0F0,       64'hFF00,       64'hF000,       1'b0, 1'b0, 1'b0);
        run_op("orr",  11'b10101010000, 64'hF0,        64'h0F,         64'd0,          4'b0001, 64'hF0,         64'h0F,         64'hFF,         1'b0, 1'b0, 1'b0);
        run_op("addi", 11'b10010001001, 64'd10,        64'd55,         64'hFFFF_FFFF_FFFF_FFFF, 4'b0010, 64'd10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd9, 1'b0, 1'b0, 1'b0);
        run_op("ldur", 11'b11111000010, 64'd100,       64'd1,          64'd8,          4'b0010, 64'd100,        64'd8,          64'd108,        1'b0, 1'b0, 1'b0);
        run_op("stur", 11'b11111000000, 64'h1000,      64'd1,          64'h10,         4'b0010, 64'h1000,       64'h10,         64'h1010,       1'b0, 1'b0, 1'b0);
        run_op("cbz0", 11'b10110100101, 64'd77,        64'd0,          64'd4,          4'b0111, 64'd77,         64'd0,          64'd0,          1'b1, 1'b1, 1'b0);
        run_op("cbz9", 11'b10110100000, 64'd77,        64'd9,          64'd4,          4'b0111, 64'd77,         64'd9,          64'd9,          1'b0, 1'b0, 1'b0);
        run_op("cbnz0",11'b10110101000, 64'd1,         64'd0,          64'd0,          4'b0111, 64'd1,          64'd0,          64'd0,          1'b1, 1'b0, 1'b0);
        run_op("cbnz9",11'b10110101111, 64'd1,         64'd9,          64'd0,          4'b0111, 64'd1,          64'd9,          64'd9,          1'b0, 1'b1, 1'b0);
        run_op("ill0", 11'b00000000000, 64'd5,         64'd6,          64'd7,          4'b0000, 64'd0,          64'd0,          64'd0,          1'b1, 1'b0, 1'b1);
        run_op("ill1", 11'b11111111111, 64'd5,         64'd6,          64'd7,          4'b0000, 64'd0,          64'd0,          64'd0,          1'b1, 1'b0, 1'b1);
        run_op("addx", 11'b10001011001, 64'd5,         64'd7,          64'd0,          4'b0000, 64'd0,          64'd0,          64'd0,          1'b1, 1'b0, 1'b1);

        // Backpressure: second instruction offered from EXEC onward must wait.
        in_valid  = 1'b1;
        opcode    = 11'b10001011000;
        rd1       = 64'd1;
        rd2       = 64'd2;
        out_ready = 1'b0;
        @(posedge clk); #1;
        opcode = 11'b11001011000;
        rd1    = 64'd9;
        rd2    = 64'd4;
        check("bp.exec_a", alu_a, 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp.in_ready", {63'd0, in_ready}, 64'd0);
            check("bp.out_valid", {63'd0, out_valid}, 64'd1);
            check("bp.result", result, 64'd3);
            check("bp.flags", {61'd0, zero, branch_taken, illegal}, 64'd0);
            check("bp.alu_a_held", alu_a, 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp.idle", {62'd0, in_ready, out_valid}, 64'd2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp.second_ctrl", {60'd0, alu_control}, 64'd6);
        check("bp.second_a", alu_a, 64'd9);
        @(posedge clk); #1;
        check("bp.second_result", result, 64'd5);
        @(posedge clk); #1;

        // Reset during EXEC after an illegal op left ZERO/ILLEGAL set.
        run_op("pre_rst", 11'b00000000000, 64'd1, 64'd1, 64'd1, 4'b0000, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, 1'b1);
        in_valid = 1'b1;
        opcode   = 11'b10001011000;
        rd1      = 64'd5;
        rd2      = 64'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("rst.in_exec", alu_a, 64'd5);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst.handshake", {62'd0, in_ready, out_valid}, 64'd2);
        check("rst.alu", {alu_a[29:0], alu_b[29:0], alu_control}, 64'd0);
        check("rst.out", {result[60:0], zero, branch_taken, illegal}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst.no_valid", {62'd0, in_ready, out_valid}, 64'd2);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
